warp_scheduler: RTL and testbench

WARP_SCHEDULER -- requirements
Module: warp_scheduler

---
 rtl/gpu_pkg.sv | 21 ++
 rtl/warp_scheduler_if.sv | 33 +++
 rtl/warp_scheduler_pc_reduce.sv | 44 ++++
 rtl/warp_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_warp_scheduler.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared definitions for the warp scheduler: FSM state encoding, default
// program-counter width and a small wrap-around index helper.
package gpu_pkg;

  localparam int GPU_PC_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_FETCH  = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DONE   = 3'd5
  } sched_state_e;

  // (base + off) modulo n, used for round-robin warp indexing.
  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage : gpu_pkg

// File: rtl/warp_scheduler_if.sv
// Bundle of launch, fetch, issue and retire signals between the warp
// scheduler (slave side) and its environment (master side).
interface warp_scheduler_if #(
  parameter int NUM_WARPS = 4,
  parameter int WARP_SIZE = 4,
  parameter int PC_WIDTH  = gpu_pkg::GPU_PC_WIDTH
);
  localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic                          start;
  logic [7:0]                    thread_count;
  logic                          done;
  logic                          fetch_req;
  logic [PC_WIDTH-1:0]           fetch_pc;
  logic                          fetch_ready;
  logic                          issue_valid;
  logic [WW-1:0]                 issue_warp;
  logic [WARP_SIZE-1:0]          issue_mask;
  logic                          exec_done;
  logic                          exec_ret;
  logic [WARP_SIZE*PC_WIDTH-1:0] next_pc;

  modport master (
    output start, thread_count, fetch_ready, exec_done, exec_ret, next_pc,
    input  done, fetch_req, fetch_pc, issue_valid, issue_warp, issue_mask
  );

  modport slave (
    input  start, thread_count, fetch_ready, exec_done, exec_ret, next_pc,
    output done, fetch_req, fetch_pc, issue_valid, issue_warp, issue_mask
  );

endinterface : warp_scheduler_if

// File: rtl/warp_scheduler_pc_reduce.sv
// Per-warp reconvergence helper: finds the lowest PC among live threads and
// the set of live threads sitting at that PC.
module warp_pc_reduce #(
  parameter int WARP_SIZE = 4,
  parameter int PC_WIDTH  = gpu_pkg::GPU_PC_WIDTH
) (
  input  logic [WARP_SIZE*PC_WIDTH-1:0] i_pcs,
  input  logic [WARP_SIZE-1:0]          i_done,
  output logic [PC_WIDTH-1:0]           o_min_pc,
  output logic [WARP_SIZE-1:0]          o_mask,
  output logic                          o_any_active
);

  logic [PC_WIDTH-1:0]  w_min;
  logic [WARP_SIZE-1:0] w_mask;
  logic                 w_any;

  // Minimum PC over live lanes, then mask of live lanes at that minimum.
  always_comb begin
    w_min  = {PC_WIDTH{1'b0}};
    w_any  = 1'b0;
    w_mask = {WARP_SIZE{1'b0}};
    for (int i = 0; i < WARP_SIZE; i++) begin
      if (!i_done[i] && (!w_any || (i_pcs[i*PC_WIDTH +: PC_WIDTH] < w_min))) begin
        w_min = i_pcs[i*PC_WIDTH +: PC_WIDTH];
        w_any = 1'b1;
      end else begin
        w_any = w_any;
      end
    end
    for (int i = 0; i < WARP_SIZE; i++) begin
      if (!i_done[i] && (i_pcs[i*PC_WIDTH +: PC_WIDTH] == w_min)) begin
        w_mask[i] = 1'b1;
      end else begin
        w_mask[i] = 1'b0;
      end
    end
  end

  assign o_min_pc     = w_min;
  assign o_mask       = w_mask;
  assign o_any_active = w_any;

endmodule : warp_pc_reduce

// File: rtl/warp_scheduler.sv
// Round-robin SIMT warp scheduler. Keeps a PC and a retired flag per thread,
// picks the next warp with live threads, fetches at the warp's lowest live
// PC, issues the lanes at that PC and applies the retire results.
module warp_scheduler
  import gpu_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int WARP_SIZE = 4,
  parameter int PC_WIDTH  = GPU_PC_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  warp_scheduler_if.slave bus
);

  localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  sched_state_e                  r_state;
  sched_state_e                  w_state_nxt;

  logic [WARP_SIZE*PC_WIDTH-1:0] r_pc    [NUM_WARPS];
  logic [WARP_SIZE-1:0]          r_tdone [NUM_WARPS];
  logic [WW-1:0]                 r_ptr;

  logic                          r_done,        w_done_nxt;
  logic                          r_fetch_req,   w_fetch_req_nxt;
  logic                          r_issue_valid, w_issue_valid_nxt;
  logic [PC_WIDTH-1:0]           r_fetch_pc,    w_fetch_pc_nxt;
  logic [WW-1:0]                 r_issue_warp,  w_issue_warp_nxt;
  logic [WARP_SIZE-1:0]          r_issue_mask,  w_issue_mask_nxt;

  logic                          w_found;
  logic [WW-1:0]                 w_sel;
  logic [PC_WIDTH-1:0]           w_red_min;
  logic [WARP_SIZE-1:0]          w_red_mask;
  logic                          w_red_any;

  // Round-robin search: first warp at or after the pointer with a live thread.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    for (int k = 0; k < NUM_WARPS; k++) begin
      if (!w_found &&
          (r_tdone[WW'(wrap_idx(int'(r_ptr), k, NUM_WARPS))] != {WARP_SIZE{1'b1}})) begin
        w_found = 1'b1;
        w_sel   = WW'(wrap_idx(int'(r_ptr), k, NUM_WARPS));
      end else begin
        w_found = w_found;
      end
    end
  end

  warp_pc_reduce #(
    .WARP_SIZE (WARP_SIZE),
    .PC_WIDTH  (PC_WIDTH)
  ) u_reduce (
    .i_pcs        (r_pc[w_sel]),
    .i_done       (r_tdone[w_sel]),
    .o_min_pc     (w_red_min),
    .o_mask       (w_red_mask),
    .o_any_active (w_red_any)
  );

  // Next-state and next-output decode; outputs are registered with the state.
  always_comb begin
    w_state_nxt       = r_state;
    w_done_nxt        = 1'b0;
    w_fetch_req_nxt   = 1'b0;
    w_issue_valid_nxt = 1'b0;
    w_issue_mask_nxt  = {WARP_SIZE{1'b0}};
    w_fetch_pc_nxt    = r_fetch_pc;
    w_issue_warp_nxt  = r_issue_warp;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_SELECT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SELECT: begin
        if (w_red_any) begin
          w_state_nxt      = ST_FETCH;
          w_fetch_req_nxt  = 1'b1;
          w_fetch_pc_nxt   = w_red_min;
          w_issue_mask_nxt = w_red_mask;
          w_issue_warp_nxt = w_sel;
        end else begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end
      end
      ST_FETCH: begin
        w_issue_mask_nxt = r_issue_mask;
        if (bus.fetch_ready) begin
          w_state_nxt       = ST_ISSUE;
          w_issue_valid_nxt = 1'b1;
        end else begin
          w_fetch_req_nxt = 1'b1;
        end
      end
      ST_ISSUE: begin
        w_state_nxt      = ST_WAIT;
        w_issue_mask_nxt = r_issue_mask;
      end
      ST_WAIT: begin
        if (bus.exec_done) begin
          w_state_nxt = ST_SELECT;
        end else begin
          w_issue_mask_nxt = r_issue_mask;
        end
      end
      ST_DONE: begin
        if (!bus.start) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_done_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_done        <= 1'b0;
      r_fetch_req   <= 1'b0;
      r_issue_valid <= 1'b0;
      r_fetch_pc    <= {PC_WIDTH{1'b0}};
      r_issue_warp  <= {WW{1'b0}};
      r_issue_mask  <= {WARP_SIZE{1'b0}};
    end else begin
      r_state       <= w_state_nxt;
      r_done        <= w_done_nxt;
      r_fetch_req   <= w_fetch_req_nxt;
      r_issue_valid <= w_issue_valid_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_issue_warp  <= w_issue_warp_nxt;
      r_issue_mask  <= w_issue_mask_nxt;
    end
  end

  // Thread context: launch initialisation and retire write-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= {WW{1'b0}};
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_pc[w]    <= {(WARP_SIZE*PC_WIDTH){1'b0}};
        r_tdone[w] <= {WARP_SIZE{1'b1}};
      end
    end else if ((r_state == ST_IDLE) && bus.start) begin
      r_ptr <= {WW{1'b0}};
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_pc[w] <= {(WARP_SIZE*PC_WIDTH){1'b0}};
        for (int i = 0; i < WARP_SIZE; i++) begin
          r_tdone[w][i] <= ((w * WARP_SIZE + i) >= int'(bus.thread_count));
        end
      end
    end else if ((r_state == ST_WAIT) && bus.exec_done) begin
      r_ptr <= WW'(wrap_idx(int'(r_issue_warp), 1, NUM_WARPS));
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (WW'(w) == r_issue_warp) begin
          for (int i = 0; i < WARP_SIZE; i++) begin
            if (r_issue_mask[i]) begin
              if (bus.exec_ret) begin
                r_tdone[w][i] <= 1'b1;
              end else begin
                r_pc[w][i*PC_WIDTH +: PC_WIDTH] <= bus.next_pc[i*PC_WIDTH +: PC_WIDTH];
              end
            end
          end
        end
      end
    end
  end

  assign bus.done        = r_done;
  assign bus.fetch_req   = r_fetch_req;
  assign bus.fetch_pc    = r_fetch_pc;
  assign bus.issue_valid = r_issue_valid;
  assign bus.issue_warp  = r_issue_warp;
  assign bus.issue_mask  = r_issue_mask;

endmodule : warp_scheduler

// File: tb/tb_warp_scheduler.sv
// Randomised bench for warp_scheduler against a thread-level reference model.
module tb_warp_scheduler;

  localparam int NW = 4;
  localparam int WS = 4;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  warp_scheduler_if #(.NUM_WARPS(NW), .WARP_SIZE(WS), .PC_WIDTH(PW)) bus ();

  warp_scheduler #(.NUM_WARPS(NW), .WARP_SIZE(WS), .PC_WIDTH(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one PC and one retired flag per thread, plus pointer.
  int m_pc   [NW*WS];
  bit m_done [NW*WS];
  int m_ptr;

  int seq_w[$];
  int seq_pc[$];
  int seq_mask[$];
  int warp_issues[NW];
  int first_mask[NW];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic void m_launch(input int tc);
    for (int g = 0; g < NW*WS; g++) begin
      m_pc[g]   = 0;
      m_done[g] = (g >= tc);
    end
    m_ptr = 0;
  endfunction

  function automatic int m_pick();
    for (int k = 0; k < NW; k++) begin
      int w;
      w = (m_ptr + k) % NW;
      for (int i = 0; i < WS; i++) begin
        if (!m_done[w*WS+i]) return w;
      end
    end
    return -1;
  endfunction

  function automatic int m_min(input int w);
    int mn;
    mn = 1 << PW;
    for (int i = 0; i < WS; i++) begin
      if (!m_done[w*WS+i] && m_pc[w*WS+i] < mn) mn = m_pc[w*WS+i];
    end
    return mn;
  endfunction

  function automatic int m_mask(input int w);
    int mk;
    int mn;
    mk = 0;
    mn = m_min(w);
    for (int i = 0; i < WS; i++) begin
      if (!m_done[w*WS+i] && m_pc[w*WS+i] == mn) mk = mk | (1 << i);
    end
    return mk;
  endfunction

  // Execution-unit behaviour: 0 = straight line, RET at 2; 1 = divergence
  // at PC 5, RET at 9; 2 = random targets, random RET.
  function automatic int pol_pc(input int mode, input int pc, input int lane);
    if (mode == 0) return (pc + 1) % (1 << PW);
    if (mode == 1) return (pc == 5) ? ((lane % 2 == 1) ? 6 : 9) : ((pc + 1) % (1 << PW));
    return int'($urandom_range(0, (1 << PW) - 1));
  endfunction

  function automatic bit pol_ret(input int mode, input int pc, input int n);
    if (mode == 0) return (pc == 2);
    if (mode == 1) return (pc == 9);
    return ($urandom_range(0, 3) == 0) || (n >= 40);
  endfunction

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_done"},   32'(bus.done),        32'd0);
    check_eq({tag, "_freq"},   32'(bus.fetch_req),   32'd0);
    check_eq({tag, "_ivalid"}, 32'(bus.issue_valid), 32'd0);
    check_eq({tag, "_mask"},   32'(bus.issue_mask),  32'd0);
    check_eq({tag, "_pc"},     32'(bus.fetch_pc),    32'd0);
    check_eq({tag, "_warp"},   32'(bus.issue_warp),  32'd0);
  endtask

  task automatic reset_in_wait();
    bus.fetch_ready = 1'b1;
    bus.exec_done   = 1'b1;
    #2 reset = 1'b0;
    #1 check_outputs_zero("rst_wait");
    repeat (3) begin
      tick();
      bus.fetch_ready = ~bus.fetch_ready;
      bus.exec_done   = ~bus.exec_done;
      check_outputs_zero("rst_hold");
    end
    bus.fetch_ready = 1'b0;
    bus.exec_done   = 1'b0;
    bus.start       = 1'b0;
    reset           = 1'b1;
    tick();
    check_eq("rst_idle_freq", 32'(bus.fetch_req), 32'd0);
    check_eq("rst_idle_done", 32'(bus.done), 32'd0);
  endtask

  task automatic run_block(input int tc, input int mode, input int abort_at,
                           output int n_issued, output int done_wait);
    int budget, exp_w, exp_pc, exp_mask, d;
    bit finished, ret;
    logic [WS*PW-1:0] nv;
    seq_w.delete();
    seq_pc.delete();
    seq_mask.delete();
    for (int w = 0; w < NW; w++) begin
      warp_issues[w] = 0;
      first_mask[w]  = -1;
    end
    m_launch(tc);
    bus.thread_count = 8'(tc);
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    n_issued  = 0;
    done_wait = -1;
    finished  = 1'b0;
    while (!finished) begin
      budget = 0;
      while (!bus.fetch_req && !bus.done && budget < 20) begin
        tick();
        budget++;
      end
      exp_w = m_pick();
      if (exp_w < 0) begin
        done_wait = budget;
        check_eq("done_high", 32'(bus.done), 32'd1);
        check_eq("done_no_freq", 32'(bus.fetch_req), 32'd0);
        check_eq("done_no_mask", 32'(bus.issue_mask), 32'd0);
        tick();
        check_eq("done_release", 32'(bus.done), 32'd0);
        finished = 1'b1;
      end else begin
        exp_pc   = m_min(exp_w);
        exp_mask = m_mask(exp_w);
        check_eq("fetch_req", 32'(bus.fetch_req), 32'd1);
        check_eq("issue_warp", 32'(bus.issue_warp), 32'(exp_w));
        check_eq("fetch_pc", 32'(bus.fetch_pc), 32'(exp_pc));
        check_eq("issue_mask", 32'(bus.issue_mask), 32'(exp_mask));
        if (!bus.fetch_req) begin
          finished = 1'b1;
        end else begin
          seq_w.push_back(exp_w);
          seq_pc.push_back(exp_pc);
          seq_mask.push_back(exp_mask);
          if (warp_issues[exp_w] == 0) first_mask[exp_w] = exp_mask;
          warp_issues[exp_w]++;
          d = int'($urandom_range(0, 2));
          repeat (d) begin
            bus.exec_done = 1'($urandom_range(0, 1));
            bus.exec_ret  = 1'($urandom_range(0, 1));
            bus.next_pc   = $urandom;
            tick();
            check_eq("fetch_hold", 32'(bus.fetch_req), 32'd1);
            check_eq("fetch_pc_stable", 32'(bus.fetch_pc), 32'(exp_pc));
          end
          bus.exec_done   = 1'b0;
          bus.exec_ret    = 1'b0;
          bus.fetch_ready = 1'b1;
          tick();
          bus.fetch_ready = 1'b0;
          check_eq("issue_pulse", 32'(bus.issue_valid), 32'd1);
          check_eq("issue_freq_low", 32'(bus.fetch_req), 32'd0);
          tick();
          check_eq("issue_single", 32'(bus.issue_valid), 32'd0);
          check_eq("wait_mask", 32'(bus.issue_mask), 32'(exp_mask));
          n_issued++;
          if (abort_at == n_issued) begin
            reset_in_wait();
            finished = 1'b1;
          end else begin
            d = int'($urandom_range(0, 2));
            repeat (d) begin
              bus.fetch_ready = 1'($urandom_range(0, 1));
              tick();
              check_eq("wait_no_valid", 32'(bus.issue_valid), 32'd0);
            end
            bus.fetch_ready = 1'b0;
            nv = '0;
            for (int i = 0; i < WS; i++) begin
              nv[i*PW +: PW] = PW'(pol_pc(mode, m_pc[exp_w*WS+i], i));
            end
            ret           = pol_ret(mode, exp_pc, n_issued);
            bus.next_pc   = nv;
            bus.exec_ret  = ret;
            bus.exec_done = 1'b1;
            tick();
            bus.exec_done = 1'b0;
            bus.exec_ret  = 1'b0;
            for (int i = 0; i < WS; i++) begin
              if (exp_mask[i]) begin
                if (ret) m_done[exp_w*WS+i] = 1'b1;
                else     m_pc[exp_w*WS+i]   = int'(nv[i*PW +: PW]);
              end
            end
            m_ptr = (exp_w + 1) % NW;
          end
        end
      end
    end
  endtask

  initial begin
    int n_iss, dw, tc;
    int ref_seq[$];
    reset            = 1'b0;
    bus.start        = 1'b0;
    bus.thread_count = 8'd0;
    bus.fetch_ready  = 1'b0;
    bus.exec_done    = 1'b0;
    bus.exec_ret     = 1'b0;
    bus.next_pc      = '0;
    repeat (3) tick();
    check_outputs_zero("reset");
    reset = 1'b1;
    tick();
    check_outputs_zero("post_reset");

    // Full block, straight-line code, RET at PC 2.
    run_block(16, 0, 0, n_iss, dw);
    check_eq("full_issue_count", 32'(n_iss), 32'd12);
    for (int k = 0; k < 12; k++) check_eq("full_rr_order", 32'(seq_w[k]), 32'(k % NW));
    ref_seq = seq_w;

    // Partial block: warp 1 half populated, warps 2/3 empty.
    run_block(6, 0, 0, n_iss, dw);
    check_eq("tc6_warp1_mask", 32'(first_mask[1]), 32'b0011);
    check_eq("tc6_warps23_idle", 32'(warp_issues[2] + warp_issues[3]), 32'd0);
    check_eq("tc6_issue_count", 32'(n_iss), 32'd6);

    // Divergence and reconvergence inside warp 0.
    run_block(4, 1, 0, n_iss, dw);
    check_eq("div_count", 32'(n_iss), 32'd10);
    check_eq("div_pc", 32'(seq_pc[6]), 32'd6);
    check_eq("div_mask", 32'(seq_mask[6]), 32'b1010);
    check_eq("reconv_pc", 32'(seq_pc[9]), 32'd9);
    check_eq("reconv_mask", 32'(seq_mask[9]), 32'b1111);

    // Empty block.
    run_block(0, 0, 0, n_iss, dw);
    check_eq("tc0_no_issue", 32'(n_iss), 32'd0);
    check_eq("tc0_fast_done", 32'((dw >= 0) && (dw <= 1)), 32'd1);

    // Reset while waiting for retire, then a fresh identical launch.
    run_block(16, 0, 5, n_iss, dw);
    run_block(16, 0, 0, n_iss, dw);
    check_eq("restart_count", 32'(n_iss), 32'd12);
    for (int k = 0; k < 12; k++) check_eq("restart_order", 32'(seq_w[k]), 32'(ref_seq[k]));

    // Random blocks with random branch targets (PCs wrap at 8 bits).
    for (int r = 0; r < 6; r++) begin
      tc = int'($urandom_range(0, 20));
      run_block(tc, 2, 0, n_iss, dw);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", n_checks, 0);
    $fatal(1, "timeout");
  end

endmodule : tb_warp_scheduler
